// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter between ALU and load writeback ports feeding a registered register-file write stage.
// Optional collision counter output coll_cnt is enabled by defining WB_ARB_COLLISION_CNT_EN.
module regfile_wb_arbiter #(
    parameter int REG_WIDTH     = 8,
    parameter int REG_DIR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    input  logic [REG_DIR_WIDTH-1:0] a_addr,
    input  logic [REG_WIDTH-1:0]     a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [REG_DIR_WIDTH-1:0] b_addr,
    input  logic [REG_WIDTH-1:0]     b_data,
    output logic                     b_ready,
    input  logic                     hold,
`ifdef WB_ARB_COLLISION_CNT_EN
    output logic [15:0]              coll_cnt,
`endif
    output logic                     RegWrite,
    output logic [REG_DIR_WIDTH-1:0] writer,
    output logic [REG_WIDTH-1:0]     writedata,
    output logic                     last_grant
);

    logic                     ptr;
    logic                     xfer;
    logic [REG_DIR_WIDTH-1:0] sel_addr;
    logic [REG_WIDTH-1:0]     sel_data;

    // Grant one requester per cycle; ptr=0 favours A, ptr=1 favours B on a collision
    always_comb begin
        a_ready  = ~hold & a_valid & (~b_valid | ~ptr);
        b_ready  = ~hold & b_valid & (~a_valid | ptr);
        xfer     = a_ready | b_ready;
        sel_addr = b_ready ? b_addr : a_addr;
        sel_data = b_ready ? b_data : a_data;
    end

    // Register the accepted write; address 0 is consumed without touching the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            RegWrite   <= 1'b0;
            writer     <= '0;
            writedata  <= '0;
            last_grant <= 1'b0;
        end else begin
            RegWrite <= xfer && (sel_addr != '0);
            if (xfer) begin
                ptr        <= a_ready;
                last_grant <= b_ready;
                if (sel_addr != '0) begin
                    writer    <= sel_addr;
                    writedata <= sel_data;
                end
            end
        end
    end

`ifdef WB_ARB_COLLISION_CNT_EN
    // Saturating count of cycles where both requesters compete outside hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coll_cnt <= '0;
        else if (a_valid && b_valid && !hold && coll_cnt != 16'hFFFF)
            coll_cnt <= coll_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven arbitration vectors with an output scoreboard, plus reset and collision sequences.
module tb_regfile_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0;
    logic [2:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, RegWrite, last_grant;
    logic [2:0] writer;
    logic [7:0] writedata;
`ifdef WB_ARB_COLLISION_CNT_EN
    logic [15:0] coll_cnt;
`endif

    regfile_wb_arbiter #(.REG_WIDTH(8), .REG_DIR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .hold(hold),
`ifdef WB_ARB_COLLISION_CNT_EN
        .coll_cnt(coll_cnt),
`endif
        .RegWrite(RegWrite), .writer(writer), .writedata(writedata), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       h, av;
        logic [2:0] aa;
        logic [7:0] ad;
        logic       bv;
        logic [2:0] ba;
        logic [7:0] bd;
        logic       ear, ebr;
    } vec_t;

    typedef struct {
        logic       rw;
        logic [2:0] w;
        logic [7:0] d;
        logic       lg;
    } exp_t;

    exp_t       q[$];
    vec_t       vt[18];
    int         compared = 0, mismatched = 0;
    logic [2:0] m_w = '0;
    logic [7:0] m_d = '0;
    logic       m_lg = 1'b0;

    function automatic vec_t mk(int h, int av, int aa, int ad, int bv, int ba, int bd, int ear, int ebr);
        vec_t v;
        v.h = 1'(h); v.av = 1'(av); v.aa = 3'(aa); v.ad = 8'(ad);
        v.bv = 1'(bv); v.ba = 3'(ba); v.bd = 8'(bd); v.ear = 1'(ear); v.ebr = 1'(ebr);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        hold = v.h; a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    endtask

    task automatic push_exp(input logic ga, input logic gb);
        exp_t e;
        e.rw = 1'b0;
        if (ga || gb) begin
            logic [2:0] ad;
            logic [7:0] dt;
            ad = gb ? b_addr : a_addr;
            dt = gb ? b_data : a_data;
            m_lg = gb;
            e.rw = (ad != 3'd0);
            if (ad != 3'd0) begin
                m_w = ad;
                m_d = dt;
            end
        end
        e.w = m_w; e.d = m_d; e.lg = m_lg;
        q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("RegWrite", 32'(RegWrite), 32'(e.rw));
            chk("writer", 32'(writer), 32'(e.w));
            chk("writedata", 32'(writedata), 32'(e.d));
            chk("last_grant", 32'(last_grant), 32'(e.lg));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_RegWrite"}, 32'(RegWrite), 32'd0);
        chk({tag, "_writer"}, 32'(writer), 32'd0);
        chk({tag, "_writedata"}, 32'(writedata), 32'd0);
        chk({tag, "_last_grant"}, 32'(last_grant), 32'd0);
    endtask

    initial begin
        vt[0]  = mk(0, 1, 3, 'h5A, 0, 0, 0,     1, 0);
        vt[1]  = mk(0, 0, 0, 0,    0, 0, 0,     0, 0);
        vt[2]  = mk(0, 0, 0, 0,    1, 5, 'h55,  0, 1);
        vt[3]  = mk(0, 1, 1, 'h11, 1, 2, 'h22,  1, 0);
        vt[4]  = mk(0, 1, 1, 'h11, 1, 2, 'h22,  0, 1);
        vt[5]  = mk(0, 1, 1, 'h11, 1, 2, 'h22,  1, 0);
        vt[6]  = mk(0, 1, 1, 'h11, 1, 2, 'h22,  0, 1);
        vt[7]  = mk(0, 1, 0, 'hFF, 0, 0, 0,     1, 0);
        vt[8]  = mk(1, 1, 1, 'h11, 1, 2, 'h22,  0, 0);
        vt[9]  = mk(1, 1, 1, 'h11, 1, 2, 'h22,  0, 0);
        vt[10] = mk(1, 1, 1, 'h11, 1, 2, 'h22,  0, 0);
        vt[11] = mk(0, 1, 1, 'h11, 1, 2, 'h22,  0, 1);
        vt[12] = mk(1, 1, 4, 'h99, 0, 0, 0,     0, 0);
        vt[13] = mk(0, 1, 4, 'h44, 0, 0, 0,     1, 0);
        vt[14] = mk(0, 1, 5, 'h45, 0, 0, 0,     1, 0);
        vt[15] = mk(0, 1, 3, 'h31, 1, 3, 'h32,  0, 1);
        vt[16] = mk(0, 1, 3, 'h31, 1, 3, 'h32,  1, 0);
        vt[17] = mk(0, 0, 0, 0,    0, 0, 0,     0, 0);

        // Reset state, with both requesters valid: pointer must favour A
        drive(mk(0, 1, 1, 'h11, 1, 2, 'h22, 0, 0));
        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset_a_ready", 32'(a_ready), 32'd1);
        chk("reset_b_ready", 32'(b_ready), 32'd0);
        drive(vt[17]);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            check_out();
            drive(vt[i]);
            #1;
            chk($sformatf("a_ready[%0d]", i), 32'(a_ready), 32'(vt[i].ear));
            chk($sformatf("b_ready[%0d]", i), 32'(b_ready), 32'(vt[i].ebr));
            push_exp(vt[i].ear, vt[i].ebr);
        end
        @(negedge clk);
        check_out();

        // A transfer, then reset asserted the following cycle
        drive(mk(0, 1, 6, 'h66, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst_a_ready", 32'(a_ready), 32'd1);
        push_exp(1'b1, 1'b0);
        @(negedge clk);
        check_out();
        drive(mk(0, 1, 7, 'h77, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        q.delete();
        m_w = '0; m_d = '0; m_lg = 1'b0;
        @(negedge clk);
        check_zero("in_rst");
        drive(vt[17]);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_zero("post_rst_idle");
        end

        // First grant after release goes to A on a collision
        drive(mk(0, 1, 1, 'h11, 1, 2, 'h22, 0, 0));
        #1;
        chk("post_rst_a_ready", 32'(a_ready), 32'd1);
        chk("post_rst_b_ready", 32'(b_ready), 32'd0);
        push_exp(1'b1, 1'b0);
        @(negedge clk);
        check_out();
        drive(vt[17]);

`ifdef WB_ARB_COLLISION_CNT_EN
        rst_n = 1'b0;
        #1;
        chk("coll_cnt_rst", 32'(coll_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(0, 1, 1, 'h11, 1, 2, 'h22, 0, 0));
        repeat (5) @(negedge clk);
        drive(vt[17]);
        @(negedge clk);
        chk("coll_cnt_5", 32'(coll_cnt), 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
